instr_fetch_queue: RTL and testbench

Front-end fetch stage that sits directly upstream of the decode stage of the pipeline CPU. It owns the instruction memory, which is loaded through a program-load port, and the fetch PC. It prefetches 16-bit instructions into a small FIFO and presents them to decode with a valid/ready handshake. Decode or EX can issue a redirect that flushes the queue and restarts fetch at a new PC.

---
 rtl/instr_fetch_queue.sv | 122 ++++++++++++
 tb/tb_instr_fetch_queue.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetch stage that owns the instruction memory and fetch PC,
// prefetches 16-bit instructions into a small FIFO and hands them to decode
// through a valid/ready handshake. A redirect flushes the queue and restarts fetch.
// Optional feature macro: FETCH_NOP_SKIP_EN. When it is defined, fetched 16'h0000
// words are dropped instead of enqueued, but they still advance fetch_pc.
module instr_fetch_queue #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned QDEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_en,
    input  logic [$clog2(DEPTH)-1:0]     load_addr,
    input  logic [15:0]                  load_data,
    input  logic                         run,
    input  logic                         redirect_valid,
    input  logic [WIDTH-1:0]             redirect_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [15:0]                  out_instr,
    output logic [WIDTH-1:0]             out_pc,
    output logic [WIDTH-1:0]             fetch_pc,
    output logic [$clog2(QDEPTH+1)-1:0]  q_count,
    output logic                         halted
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

    logic [15:0]      imem_q    [DEPTH];
    logic [15:0]      q_instr_q [QDEPTH];
    logic [WIDTH-1:0] q_pc_q    [QDEPTH];

    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic        in_range;
    logic [15:0] fetch_word;
    logic        is_nop;
    logic        full;
    logic        pop;
    logic        fetch_go;
    logic        enq;

    // Fetch/handshake qualifiers; the memory read sees the pre-write word.
    always_comb begin
        in_range   = (fetch_pc_q < WIDTH'(DEPTH));
        fetch_word = imem_q[fetch_pc_q[AW-1:0]];
`ifdef FETCH_NOP_SKIP_EN
        is_nop     = (fetch_word == 16'h0000);
`else
        is_nop     = 1'b0;
`endif
        full       = (count_q == CNT_W'(QDEPTH));
        pop        = out_valid & out_ready;
        // A full queue accepts a new fetch only when the head leaves this cycle.
        fetch_go   = run & ~redirect_valid & in_range & (~full | pop);
        enq        = fetch_go & ~is_nop;
    end

    // Next-state for fetch PC and queue bookkeeping; redirect wins over push/pop.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (fetch_go) fetch_pc_d = fetch_pc_q + WIDTH'(1);
            if (enq)      wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            if (pop)      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(enq) - CNT_W'(pop);
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Instruction memory write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (load_en) imem_q[load_addr] <= load_data;
    end

    // Queue payload storage; stale entries are masked by out_valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_pc_q[wr_ptr_q]    <= fetch_pc_q;
            q_instr_q[wr_ptr_q] <= fetch_word;
        end
    end

    // Output view of the queue head, zeroed when empty.
    always_comb begin
        out_valid = (count_q != '0);
        out_instr = out_valid ? q_instr_q[rd_ptr_q] : 16'h0000;
        out_pc    = out_valid ? q_pc_q[rd_ptr_q] : '0;
        fetch_pc  = fetch_pc_q;
        q_count   = count_q;
        halted    = ~in_range & (count_q == '0);
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with hand-computed expectations.
module tb_instr_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [15:0] load_data;
    logic        run;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] fetch_pc;
    logic [2:0]  q_count;
    logic        halted;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [15:0] words [16];

    instr_fetch_queue #(.WIDTH(32), .DEPTH(16), .QDEPTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .load_en        (load_en),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .run            (run),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_pc       (fetch_pc),
        .q_count        (q_count),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are settled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic load_word(input logic [3:0] a, input logic [15:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc, input logic [15:0] instr);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".pc"},    out_pc, pc);
        check({tag, ".instr"}, 32'(out_instr), 32'(instr));
    endtask

    initial begin
        // Distinct nonzero words beyond pc3 so ordering is observable.
        words[0] = 16'h1105;
        words[1] = 16'h120A;
        words[2] = 16'h2312;
        words[3] = 16'h3431;
        for (int i = 4; i < 16; i++) words[i] = 16'hA000 | 16'(i);

        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        run = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        tick();
        check("rst.valid",  32'(out_valid), 32'd0);
        check("rst.instr",  32'(out_instr), 32'd0);
        check("rst.pc",     out_pc, 32'd0);
        check("rst.fpc",    fetch_pc, 32'd0);
        check("rst.count",  32'(q_count), 32'd0);
        check("rst.halted", 32'(halted), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) load_word(4'(i), words[i]);

        // Test 1: streaming with first valid one cycle after run.
        pulse_reset();
        run = 1'b1; out_ready = 1'b1;
        check("t1.pre_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_head($sformatf("t1.%0d", i), 32'(i), words[i]);
        end

        // Test 2: backpressure fills the queue, then drains in order.
        run = 1'b0;
        pulse_reset();
        run = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        check("t2.count", 32'(q_count), 32'd4);
        check("t2.fpc",   fetch_pc, 32'd4);
        expect_head("t2.hold", 32'd0, words[0]);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            expect_head($sformatf("t2.%0d", i), 32'(i), words[i]);
            tick();
        end
        check("t2.count_full_flow", 32'(q_count), 32'd4);

        // Test 3: redirect flushes a partially filled queue.
        run = 1'b0;
        pulse_reset();
        run = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("t3.count_pre", 32'(q_count), 32'd3);
        redirect_valid = 1'b1; redirect_pc = 32'd2;
        tick();
        check("t3.valid", 32'(out_valid), 32'd0);
        check("t3.count", 32'(q_count), 32'd0);
        check("t3.fpc",   fetch_pc, 32'd2);
        redirect_valid = 1'b0; out_ready = 1'b1;
        tick();
        expect_head("t3.head", 32'd2, words[2]);

        // Test 4: running off the end of memory halts, redirect restarts.
        run = 1'b0;
        pulse_reset();
        run = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            expect_head($sformatf("t4.%0d", i), 32'(i), words[i]);
        end
        check("t4.halt_not_drained", 32'(halted), 32'd0);
        tick();
        check("t4.fpc",    fetch_pc, 32'd16);
        check("t4.halted", 32'(halted), 32'd1);
        check("t4.valid",  32'(out_valid), 32'd0);
        check("t4.pc0",    out_pc, 32'd0);
        tick(); tick();
        check("t4.valid_stays", 32'(out_valid), 32'd0);
        check("t4.fpc_stays",   fetch_pc, 32'd16);
        redirect_valid = 1'b1; redirect_pc = 32'd0;
        tick();
        check("t4.unhalt", 32'(halted), 32'd0);
        redirect_valid = 1'b0;
        tick();
        expect_head("t4.restart", 32'd0, words[0]);

        // Test 5: asynchronous reset between edges, memory retained.
        run = 1'b0;
        pulse_reset();
        run = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("t5.count_pre", 32'(q_count), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("t5.valid", 32'(out_valid), 32'd0);
        check("t5.count", 32'(q_count), 32'd0);
        check("t5.fpc",   fetch_pc, 32'd0);
        reset = 1'b0; out_ready = 1'b1;
        tick();
        expect_head("t5.head", 32'd0, words[0]);

        // Test 6: NOP handling.
        run = 1'b0; out_ready = 1'b0;
        tick();
        load_word(4'd0, 16'h1105);
        load_word(4'd1, 16'h0000);
        load_word(4'd2, 16'h120A);
        pulse_reset();
        run = 1'b1; out_ready = 1'b1;
        tick();
        expect_head("t6.a", 32'd0, 16'h1105);
        tick();
`ifdef FETCH_NOP_SKIP_EN
        check("t6.skip_valid", 32'(out_valid), 32'd0);
`else
        expect_head("t6.nop", 32'd1, 16'h0000);
`endif
        tick();
        expect_head("t6.b", 32'd2, 16'h120A);
        run = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
